// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler for the DDS tuning word: steps freq_ctl from a start
// to a stop value with a programmable dwell, in single, sawtooth or triangle mode.
module dds_sweep_ctrl #(
    parameter int FW = 32,
    parameter int DW = 24
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic [FW-1:0] cfg_start_freq,
    input  logic [FW-1:0] cfg_stop_freq,
    input  logic [FW-1:0] cfg_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic [1:0]    cfg_mode,
    input  logic          start,
    input  logic          abort,
    output logic [FW-1:0] freq_ctl,
    output logic          busy,
    output logic          step_strobe,
    output logic          sweep_done,
    output logic          cfg_err
);

    typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

    state_t        state;
    logic [FW-1:0] start_r;
    logic [FW-1:0] stop_r;
    logic [FW-1:0] step_r;
    logic [DW-1:0] dwell_r;
    logic [1:0]    mode_r;
    logic [DW-1:0] cnt;
    logic          dir_down;

    function automatic logic [DW-1:0] dwell_or_one(input logic [DW-1:0] d);
        return (d == '0) ? DW'(1) : d;
    endfunction

    // Sum in FW+1 bits so a carry out saturates to the limit instead of wrapping.
    function automatic logic [FW-1:0] add_clamp(input logic [FW-1:0] a,
                                                 input logic [FW-1:0] b,
                                                 input logic [FW-1:0] lim);
        logic [FW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[FW-1:0];
    endfunction

    function automatic logic [FW-1:0] sub_clamp(input logic [FW-1:0] a,
                                                 input logic [FW-1:0] b,
                                                 input logic [FW-1:0] lim);
        logic [FW:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return (diff[FW] || (diff[FW-1:0] < lim)) ? lim : diff[FW-1:0];
    endfunction

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            freq_ctl    <= '0;
            busy        <= 1'b0;
            step_strobe <= 1'b0;
            sweep_done  <= 1'b0;
            cfg_err     <= 1'b0;
            start_r     <= '0;
            stop_r      <= '0;
            step_r      <= '0;
            dwell_r     <= '0;
            mode_r      <= '0;
            cnt         <= '0;
            dir_down    <= 1'b0;
        end else begin
            step_strobe <= 1'b0;
            sweep_done  <= 1'b0;
            cfg_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (cfg_start_freq <= cfg_stop_freq) begin
                            start_r     <= cfg_start_freq;
                            stop_r      <= cfg_stop_freq;
                            step_r      <= cfg_step;
                            dwell_r     <= dwell_or_one(cfg_dwell);
                            mode_r      <= cfg_mode;
                            cnt         <= dwell_or_one(cfg_dwell);
                            dir_down    <= 1'b0;
                            freq_ctl    <= cfg_start_freq;
                            busy        <= 1'b1;
                            step_strobe <= 1'b1;
                            state       <= DWELL;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                DWELL: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt > DW'(1)) begin
                        cnt <= cnt - DW'(1);
                    end else begin
                        cnt <= dwell_r;
                        // A zero step below the end point leaves the word parked: no strobe.
                        if (!dir_down) begin
                            if (freq_ctl < stop_r) begin
                                freq_ctl    <= add_clamp(freq_ctl, step_r, stop_r);
                                step_strobe <= (step_r != '0);
                            end else begin
                                case (mode_r)
                                    2'b01: begin
                                        freq_ctl    <= start_r;
                                        step_strobe <= 1'b1;
                                    end
                                    2'b10: begin
                                        dir_down    <= 1'b1;
                                        freq_ctl    <= sub_clamp(freq_ctl, step_r, start_r);
                                        step_strobe <= 1'b1;
                                    end
                                    default: begin
                                        busy       <= 1'b0;
                                        sweep_done <= 1'b1;
                                        state      <= DONE;
                                    end
                                endcase
                            end
                        end else begin
                            if (freq_ctl > start_r) begin
                                freq_ctl    <= sub_clamp(freq_ctl, step_r, start_r);
                                step_strobe <= (step_r != '0);
                            end else begin
                                dir_down    <= 1'b0;
                                freq_ctl    <= add_clamp(freq_ctl, step_r, stop_r);
                                step_strobe <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: a per-sweep sequence model compared every cycle,
// plus literal expectations for the documented sweep examples.
module tb_dds_sweep_ctrl;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg_start_freq = '0;
    logic [31:0] cfg_stop_freq = '0;
    logic [31:0] cfg_step = '0;
    logic [23:0] cfg_dwell = '0;
    logic [1:0]  cfg_mode = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] freq_ctl;
    logic        busy, step_strobe, sweep_done, cfg_err;

    int tests = 0;
    int fails = 0;

    dds_sweep_ctrl #(.FW(32), .DW(24)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .cfg_start_freq(cfg_start_freq), .cfg_stop_freq(cfg_stop_freq),
        .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
        .start(start), .abort(abort),
        .freq_ctl(freq_ctl), .busy(busy), .step_strobe(step_strobe),
        .sweep_done(sweep_done), .cfg_err(cfg_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A sweep is described by one period of tuning words; the expected word at
    // cycle t after the start command is period[((t-1)/D) mod N].
    longint      m_vals[$];
    int          m_state = 0;   // 0 idle, 1 sweeping, 2 completion cycle
    int          m_t = 0;
    int          m_d = 1;
    bit          m_single = 0;
    bit          m_step0 = 0;
    longint      m_stop = 0;
    logic [31:0] exp_freq = '0;
    logic        exp_busy = 0, exp_strobe = 0, exp_done = 0, exp_err = 0;

    task automatic build_period(input longint s, input longint e, input longint st, input bit tri_mode);
        longint v;
        m_vals.delete();
        v = s;
        m_vals.push_back(v);
        while (v < e) begin
            v = (v + st > e) ? e : v + st;
            m_vals.push_back(v);
        end
        if (tri_mode) begin
            v = e;
            forever begin
                v = (v - st < s) ? s : v - st;
                if (v == s) break;
                m_vals.push_back(v);
            end
        end
    endtask

    task automatic model_step();
        int ph, idx;
        exp_strobe = 0;
        exp_done = 0;
        exp_err = 0;
        if (rst) begin
            m_state = 0;
            exp_freq = '0;
            exp_busy = 0;
        end else begin
            case (m_state)
                0: if (start && !abort) begin
                    if (cfg_start_freq <= cfg_stop_freq) begin
                        m_d = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
                        m_single = (cfg_mode == 2'd0) || (cfg_mode == 2'd3);
                        m_step0 = (cfg_step == 0) && (cfg_start_freq != cfg_stop_freq);
                        m_stop = longint'(cfg_stop_freq);
                        if (m_step0) begin
                            m_vals.delete();
                            m_vals.push_back(longint'(cfg_start_freq));
                        end else begin
                            build_period(longint'(cfg_start_freq), longint'(cfg_stop_freq),
                                         longint'(cfg_step), cfg_mode == 2'd2);
                        end
                        m_t = 1;
                        m_state = 1;
                        exp_freq = cfg_start_freq;
                        exp_busy = 1;
                        exp_strobe = 1;
                    end else begin
                        exp_err = 1;
                    end
                end
                1: if (abort) begin
                    m_state = 0;
                    exp_busy = 0;
                end else if (!m_step0) begin
                    m_t++;
                    ph = (m_t - 1) % m_d;
                    idx = (m_t - 1) / m_d;
                    if (m_single && idx >= m_vals.size()) begin
                        m_state = 2;
                        exp_done = 1;
                        exp_busy = 0;
                        exp_freq = m_stop[31:0];
                    end else begin
                        exp_freq = m_vals[idx % m_vals.size()][31:0];
                        exp_strobe = (ph == 0);
                    end
                end
                default: m_state = 0;
            endcase
        end
    endtask

    initial forever begin
        @(posedge sys_clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge sys_clk);
        check("mdl_freq", freq_ctl, exp_freq);
        check("mdl_busy", busy, exp_busy);
        check("mdl_strobe", step_strobe, exp_strobe);
        check("mdl_done", sweep_done, exp_done);
        check("mdl_err", cfg_err, exp_err);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #2;
        end
    endtask

    task automatic set_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                           input logic [23:0] dw, input logic [1:0] md);
        cfg_start_freq = s;
        cfg_stop_freq = e;
        cfg_step = st;
        cfg_dwell = dw;
        cfg_mode = md;
    endtask

    task automatic pulse_start();
        start = 1;
        tick(1);
        start = 0;
    endtask

    logic [31:0] tri_seq [6] = '{100, 110, 120, 110, 100, 110};

    initial begin
        tick(2);
        rst = 0;
        check("rst_freq", freq_ctl, 0);
        check("rst_busy", busy, 0);
        check("rst_done", sweep_done, 0);
        tick(1);

        // single sweep 100..130 step 10 dwell 3
        set_cfg(100, 130, 10, 3, 2'd0);
        pulse_start();
        check("single_c1_freq", freq_ctl, 100);
        check("single_c1_strobe", step_strobe, 1);
        check("single_c1_busy", busy, 1);
        tick(2);
        check("single_c3_freq", freq_ctl, 100);
        check("single_c3_strobe", step_strobe, 0);
        tick(1);
        check("single_c4_freq", freq_ctl, 110);
        check("single_c4_strobe", step_strobe, 1);
        tick(6);
        check("single_c10_freq", freq_ctl, 130);
        tick(3);
        check("single_c13_done", sweep_done, 1);
        check("single_c13_busy", busy, 0);
        check("single_c13_freq", freq_ctl, 130);
        tick(1);
        check("single_c14_done", sweep_done, 0);
        check("single_c14_freq", freq_ctl, 130);

        // clamp at stop
        set_cfg(100, 125, 10, 1, 2'd0);
        pulse_start();
        tick(3);
        check("clamp_freq", freq_ctl, 125);
        tick(1);
        check("clamp_done", sweep_done, 1);
        tick(1);

        // no wrap at the top of the range
        set_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 1, 2'd0);
        pulse_start();
        check("ovf_c1", freq_ctl, 32'hFFFF_FFF0);
        tick(1);
        check("ovf_c2", freq_ctl, 32'hFFFF_FFFF);
        tick(1);
        check("ovf_done", sweep_done, 1);
        check("ovf_freq", freq_ctl, 32'hFFFF_FFFF);
        tick(1);

        // triangle then abort
        set_cfg(100, 120, 10, 1, 2'd2);
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            check("tri_freq", freq_ctl, tri_seq[i]);
            check("tri_strobe", step_strobe, 1);
            if (i < 5) tick(1);
        end
        abort = 1;
        tick(1);
        abort = 0;
        check("abort_freq", freq_ctl, 110);
        check("abort_busy", busy, 0);
        check("abort_done", sweep_done, 0);
        check("abort_strobe", step_strobe, 0);
        tick(1);

        // repeat with dwell 0; start while busy is ignored
        set_cfg(100, 120, 10, 0, 2'd1);
        pulse_start();
        check("rep_c1", freq_ctl, 100);
        tick(1);
        check("rep_c2", freq_ctl, 110);
        set_cfg(500, 600, 1, 5, 2'd0);
        pulse_start();
        check("rep_c3", freq_ctl, 120);
        check("rep_busy_start_err", cfg_err, 0);
        tick(1);
        check("rep_c4", freq_ctl, 100);
        tick(1);
        check("rep_c5", freq_ctl, 110);
        abort = 1;
        tick(1);
        abort = 0;
        tick(1);

        // rejected configuration
        set_cfg(200, 100, 10, 1, 2'd0);
        pulse_start();
        check("err_pulse", cfg_err, 1);
        check("err_busy", busy, 0);
        check("err_freq", freq_ctl, 110);
        tick(1);
        check("err_clear", cfg_err, 0);

        // start and abort together in idle
        set_cfg(100, 120, 10, 1, 2'd0);
        start = 1;
        abort = 1;
        tick(1);
        start = 0;
        abort = 0;
        check("sa_busy", busy, 0);
        check("sa_strobe", step_strobe, 0);
        check("sa_freq", freq_ctl, 110);
        tick(1);

        // asynchronous reset mid-sweep
        set_cfg(100, 130, 10, 3, 2'd0);
        pulse_start();
        tick(1);
        #1 rst = 1;
        #1;
        check("arst_freq", freq_ctl, 0);
        check("arst_busy", busy, 0);
        check("arst_strobe", step_strobe, 0);
        tick(1);
        rst = 0;
        tick(3);
        check("arst_idle_busy", busy, 0);
        check("arst_idle_freq", freq_ctl, 0);

        // randomized sweeps against the model
        for (int it = 0; it < 40; it++) begin
            logic [31:0] s, e, st;
            longint top;
            int sel;
            s = $urandom;
            if ($urandom_range(0, 5) == 0) s = 32'hFFFF_FF80 + $urandom_range(0, 127);
            top = longint'(s) + longint'($urandom_range(0, 80));
            e = (top > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : top[31:0];
            if ($urandom_range(0, 7) == 0) begin
                if (s < 32'd100) s = 32'd100;
                e = s - 32'd1 - $urandom_range(0, 50);
            end
            sel = $urandom_range(0, 9);
            if (sel == 0) st = 0;
            else if (sel == 1) st = 32'h8000_0000 + $urandom_range(0, 1000);
            else st = $urandom_range(1, 30);
            set_cfg(s, e, st, 24'($urandom_range(0, 4)), 2'($urandom_range(0, 3)));
            pulse_start();
            for (int c = 0; c < int'($urandom_range(3, 50)); c++) begin
                start = ($urandom_range(0, 19) == 0);
                abort = ($urandom_range(0, 39) == 0);
                tick(1);
                start = 0;
                abort = 0;
            end
            abort = 1;
            tick(1);
            abort = 0;
            tick(2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
